branch_tag_allocator: RTL

- Owns the branch-mask (b_mask) state for the OoO core.
- Grants free branch-stack slots (one-hot tags) to branches in the dispatch group, in program order.
- Produces the b_mask each dispatched instruction carries.
- Frees slots on branch resolve; on mispredict, squashes all slots younger than the mispredicted branch.
- Sits between dispatch and the branch stack. Its registered mask is the branch stack's next_b_mask source.

---
 rtl/branch_tag_allocator_pkg.sv | 32 +++
 rtl/branch_tag_allocator_checker.sv | 27 ++
 rtl/branch_tag_allocator_free_slot_picker.sv | 45 ++++
 rtl/branch_tag_allocator.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/branch_tag_allocator_pkg.sv
// Shared types and helpers for the branch tag allocator.
//   B_MASK_WIDTH   : number of branch-stack slots (bits in a b_mask)
//   DISPATCH_WIDTH : dispatch lanes per cycle, lane 0 is oldest
//   b_mask_t       : one bit per branch-stack slot
//   free_cnt_t     : wide enough to hold 0..B_MASK_WIDTH
package branch_tag_allocator_pkg;

  localparam int B_MASK_WIDTH   = 4;
  localparam int DISPATCH_WIDTH = 2;
  localparam int FREE_CNT_WIDTH = $clog2(B_MASK_WIDTH + 1);

  typedef logic [B_MASK_WIDTH-1:0]   b_mask_t;
  typedef logic [FREE_CNT_WIDTH-1:0] free_cnt_t;

  localparam b_mask_t B_MASK_ONE = b_mask_t'(1);

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input b_mask_t v);
    return (v != '0) && ((v & (v - B_MASK_ONE)) == '0);
  endfunction

  // Number of set bits in v.
  function automatic free_cnt_t count_ones(input b_mask_t v);
    free_cnt_t n;
    n = '0;
    for (int i = 0; i < B_MASK_WIDTH; i++) begin
      n = n + free_cnt_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_tag_allocator_checker.sv
// Flags illegal resolve-bus inputs; the allocator treats them as no-ops.
//   clock, reset  : allocator clock / synchronous reset
//   b_mm_resolve  : resolve tag bus
//   b_mm_mispred  : resolve mispredict flag
//   b_mask_q      : allocator's registered live mask
module branch_tag_allocator_checker
  import branch_tag_allocator_pkg::*;
(
  input logic                    clock,
  input logic                    reset,
  input logic [B_MASK_WIDTH-1:0] b_mm_resolve,
  input logic                    b_mm_mispred,
  input logic [B_MASK_WIDTH-1:0] b_mask_q
);

  // Resolve must name exactly one allocated slot; mispredict needs a resolve.
  always @(posedge clock) begin
    if (reset) begin
    end else if (b_mm_resolve != '0) begin
      a_resolve_onehot: assert (is_onehot(b_mm_resolve));
      a_resolve_live:   assert ((b_mm_resolve & b_mask_q) != '0);
    end else begin
      a_mispred_needs_resolve: assert (!b_mm_mispred);
    end
  end

endmodule

// File: rtl/branch_tag_allocator_free_slot_picker.sv
// Combinational in-order slot picker.
// Each requesting lane takes the lowest free index not already taken by an
// older lane. Once a requesting lane fails to get a slot, every younger lane
// is refused too, so grants always form an in-order prefix of the requests.
//   free_vec : 1 = slot available
//   req      : per-lane request, lane 0 oldest
//   grant    : per-lane grant
//   tag      : one-hot slot per granted lane, 0 for ungranted lanes
module branch_tag_allocator_free_slot_picker #(
  parameter int N = 4,
  parameter int L = 2
) (
  input  logic [N-1:0]        free_vec,
  input  logic [L-1:0]        req,
  output logic [L-1:0]        grant,
  output logic [L-1:0][N-1:0] tag
);

  logic [N-1:0] remaining;
  logic [N-1:0] lowest;
  logic         chain_ok;

  // Walk the lanes oldest-first, peeling the lowest set bit off the free vector.
  always_comb begin
    grant     = '0;
    tag       = '0;
    remaining = free_vec;
    lowest    = '0;
    chain_ok  = 1'b1;
    for (int i = 0; i < L; i++) begin
      // x & -x isolates the lowest set bit
      lowest = remaining & (~remaining + {{(N-1){1'b0}}, 1'b1});
      if (req[i] && chain_ok && (remaining != '0)) begin
        grant[i]  = 1'b1;
        tag[i]    = lowest;
        remaining = remaining & ~lowest;
      end else if (req[i]) begin
        chain_ok = 1'b0;
      end else begin
        chain_ok = chain_ok;
      end
    end
  end

endmodule

// File: rtl/branch_tag_allocator.sv
// Branch-mask owner for the OoO core.
// Grants one-hot branch-stack tags to dispatching branches in program order,
// produces each lane's b_mask, frees slots on resolve and squashes younger
// slots on mispredict.
//   clock, reset   : clock, synchronous active-high reset
//   branch_req     : lane i holds a branch needing a tag
//   branch_grant   : lane i granted this cycle (combinational)
//   branch_tag     : one-hot tag per granted lane, 0 otherwise
//   lane_b_mask    : b_mask carried by lane i's instruction
//   b_mm_resolve   : one-hot resolving tag, 0 = none
//   b_mm_mispred   : resolving branch mispredicted
//   next_b_mask    : mask after this cycle's frees and grants
//   b_mask         : registered live mask
//   free_count     : registered number of free slots
//   stall          : some requesting lane was not granted
module branch_tag_allocator
  import branch_tag_allocator_pkg::*;
(
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [DISPATCH_WIDTH-1:0]                    branch_req,
  output logic [DISPATCH_WIDTH-1:0]                    branch_grant,
  output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0]  branch_tag,
  output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0]  lane_b_mask,
  input  logic [B_MASK_WIDTH-1:0]                      b_mm_resolve,
  input  logic                                         b_mm_mispred,
  output logic [B_MASK_WIDTH-1:0]                      next_b_mask,
  output logic [B_MASK_WIDTH-1:0]                      b_mask,
  output logic [FREE_CNT_WIDTH-1:0]                    free_count,
  output logic                                         stall
);

  b_mask_t   b_mask_q, b_mask_d;
  b_mask_t   dep_q [B_MASK_WIDTH];
  b_mask_t   dep_d [B_MASK_WIDTH];
  free_cnt_t free_count_q, free_count_d;

  logic                      resolve_valid;
  logic                      mispred_eff;
  logic                      correct_eff;
  b_mask_t                   clear_mask;
  b_mask_t                   avail;
  b_mask_t                   granted_tags;
  logic [DISPATCH_WIDTH-1:0] pick_req;

  // Illegal resolves (multi-hot, unallocated tag) are ignored entirely.
  assign resolve_valid = is_onehot(b_mm_resolve) && ((b_mm_resolve & b_mask_q) != '0);
  assign mispred_eff   = resolve_valid && b_mm_mispred;
  assign correct_eff   = resolve_valid && !b_mm_mispred;

  // Slots leaving this cycle: the resolved tag, plus on a mispredict every
  // slot that was allocated while the resolved tag was live.
  always_comb begin
    clear_mask = '0;
    if (resolve_valid) begin
      clear_mask = b_mm_resolve;
      for (int k = 0; k < B_MASK_WIDTH; k++) begin
        if (mispred_eff && ((dep_q[k] & b_mm_resolve) != '0)) begin
          clear_mask[k] = 1'b1;
        end else begin
          clear_mask[k] = clear_mask[k];
        end
      end
    end else begin
      clear_mask = '0;
    end
  end

  assign avail = b_mask_q & ~clear_mask;

  // The mispredict squashes the whole dispatch group, so nothing is granted.
  // Picking from b_mask_q (not avail) keeps freed tags out of reuse for a cycle.
  assign pick_req = mispred_eff ? '0 : branch_req;

  branch_tag_allocator_free_slot_picker #(
    .N (B_MASK_WIDTH),
    .L (DISPATCH_WIDTH)
  ) u_picker (
    .free_vec (~b_mask_q),
    .req      (pick_req),
    .grant    (branch_grant),
    .tag      (branch_tag)
  );

  // Each lane sees the live mask plus the tags of older granted lanes.
  always_comb begin
    granted_tags = '0;
    lane_b_mask  = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      lane_b_mask[i] = avail | granted_tags;
      granted_tags   = granted_tags | branch_tag[i];
    end
    next_b_mask = avail | granted_tags;
  end

  assign stall = !mispred_eff && ((branch_req & ~branch_grant) != '0);

  // Next live mask and free count.
  always_comb begin
    b_mask_d     = next_b_mask;
    free_count_d = free_cnt_t'(B_MASK_WIDTH) - count_ones(next_b_mask);
  end

  // Dependency update: newly granted slots record their lane mask, freed
  // slots forget everything, and a correct resolve drops its bit everywhere.
  always_comb begin
    for (int k = 0; k < B_MASK_WIDTH; k++) begin
      if (correct_eff) begin
        dep_d[k] = dep_q[k] & ~b_mm_resolve;
      end else begin
        dep_d[k] = dep_q[k];
      end
      if (clear_mask[k]) begin
        dep_d[k] = '0;
      end else begin
        dep_d[k] = dep_d[k];
      end
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (branch_tag[i][k]) begin
          dep_d[k] = lane_b_mask[i];
        end else begin
          dep_d[k] = dep_d[k];
        end
      end
    end
  end

  // State registers; reset discards every outstanding tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      b_mask_q     <= '0;
      free_count_q <= free_cnt_t'(B_MASK_WIDTH);
      for (int k = 0; k < B_MASK_WIDTH; k++) begin
        dep_q[k] <= '0;
      end
    end else begin
      b_mask_q     <= b_mask_d;
      free_count_q <= free_count_d;
      for (int k = 0; k < B_MASK_WIDTH; k++) begin
        dep_q[k] <= dep_d[k];
      end
    end
  end

  assign b_mask     = b_mask_q;
  assign free_count = free_count_q;

  branch_tag_allocator_checker u_checker (
    .clock        (clock),
    .reset        (reset),
    .b_mm_resolve (b_mm_resolve),
    .b_mm_mispred (b_mm_mispred),
    .b_mask_q     (b_mask_q)
  );

endmodule
